sync_fifowr_arb: RTL and testbench
==================================

Name: sync_fifowr_arb

Overview:
- Round-robin write-port arbiter for one synchronous FIFO write controller.
- Shares a single FIFO write port (wfifo/wdata, gated by registered wfull) between NREQ requesters.
- Grants are bursts of up to BURST beats.
- Sits between AHB-side producers and the FIFO write control / storage.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IW, 2, width of grant index; must equal clog2(NREQ).
- DW, 32, data width per requester.
- BURST, 4, maximum accepted beats per grant (1..16).

Ports:
- wclk  input  1  write clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_i  input  NREQ  per-requester write request; level, held while data valid.
- wdata_i  input  NREQ*DW  packed data; requester k at [k*DW +: DW].
- ack_o  output  NREQ  one-hot; beat from requester k accepted this cycle.
- wfull_i  input  1  registered full flag from FIFO write control.
- wfifo_o  output  1  FIFO write request.
- wdata_o  output  DW  data to FIFO storage.
- gnt_id_o  output  IW  current owner index (registered).
- busy_o  output  1  high while in BURST state.

Behaviour:
- Reset values: state=IDLE, gnt_id=0, last=NREQ-1, cnt=0, wfifo_o=0, ack_o=0, busy_o=0.
  - Reset takes effect asynchronously, including mid-burst.
  - No partial beat is written after rst_n falls.
- States:
  - IDLE: no owner.
  - BURST: owner = gnt_id.
- Round-robin pick: first k with req_i[k]=1, scanning last+1, last+2, ... modulo NREQ.
  - On every grant: last <= winner, gnt_id <= winner, cnt <= 0.
- IDLE -> BURST: when |req_i. Winner is registered, so the first beat is no earlier than the next cycle (1-cycle arbitration latency).
- Beat acceptance in BURST:
  - accept = req_i[gnt_id] & ~wfull_i.
  - wfifo_o = accept; ack_o = accept << gnt_id.
  - wdata_o = wdata_i slice of gnt_id whenever in BURST, 0 in IDLE.
  - wfifo_o and ack_o are combinational from req_i/wfull_i. Safe because wfull_i is registered upstream.
- cnt increments on each accept. cnt width = clog2(BURST)+1; no wrap within a burst.
- Exit condition in BURST: (accept & cnt==BURST-1) | ~req_i[gnt_id].
  - On exit with any req_i set: re-arbitrate in the same cycle and stay in BURST with the new winner. No dead cycle between back-to-back bursts.
  - Rotation starts at old owner+1, so a continuing owner is considered last.
  - On exit with no req_i set: -> IDLE.
- wfull_i high in BURST:
  - No accept; cnt and owner are held.
  - The owner keeps the grant indefinitely while req_i[gnt_id] stays high.
- Owner drops req_i (with or without full): the burst ends immediately, no write that cycle, re-arbitration as above.
- Requests from non-owners are ignored until an exit; they produce no ack.
- busy_o = (state==BURST). gnt_id_o holds its last value in IDLE.
- Requesters must keep data stable until ack_o[k].

Optional Feature:
- Macro: SYNC_FIFOWR_ARB_PRIO_EN.
- Defined:
  - Requester 0 is strict high priority at every arbitration point (IDLE grant and burst exit). If req_i[0]=1, it wins regardless of last; otherwise the round-robin rule applies.
  - No preemption of a running burst.
  - last is still updated on every grant.
- Undefined: pure round-robin, as described in Behaviour.

Test Plan:
- BURST=4, only req_i[1] high for 6 beats, wfull_i=0:
  - Cycle 0: grant, no write.
  - Cycles 1-4: ack_o=0010, wfifo_o=1.
  - Cycle 5: immediate regrant to 1; beats 5-6 acked.
  - Then IDLE, busy_o=0.
- All four req_i held high, wfull_i=0: grants in order 0,1,2,3,0, 4 beats each; wfifo_o=1 every cycle after the first arbitration cycle.
- wfull_i high for 3 cycles after owner's 2nd beat: wfifo_o=0, ack_o=0 during stall; owner unchanged; exactly 4 beats total; next owner granted after the 4th.
- Owner 2 drops req_i after 2 beats while req_i[3]=1: no write in the drop cycle; gnt_id_o=3 next cycle; 3's beats follow.
- rst_n pulsed low mid-burst of owner 1: wfifo_o, ack_o, busy_o go 0 immediately. After release with req_i=1100, the first grant goes to 2 (last reset to 3).
- With SYNC_FIFOWR_ARB_PRIO_EN and req_i[0], req_i[2] held high: gnt_id_o=0 at every arbitration. Without the macro: grants alternate 0,2,0,2.

Source files
------------

// File: rtl/sync_fifowr_arb.sv
// sync_fifowr_arb: round-robin burst arbiter sharing one FIFO write port among NREQ requesters
//   wclk, rst_n           : write clock, async active-low reset
//   req_i, wdata_i, ack_o : per-requester request level, packed data, one-hot beat accept
//   wfull_i               : registered FIFO full flag
//   wfifo_o, wdata_o      : FIFO write strobe and data
//   gnt_id_o, busy_o      : registered owner index, high while a burst is running
//   SYNC_FIFOWR_ARB_PRIO_EN : when defined, requester 0 wins every arbitration it takes part in
module sync_fifowr_arb #(
  parameter int NREQ  = 4,
  parameter int IW    = 2,
  parameter int DW    = 32,
  parameter int BURST = 4
) (
  input  logic               wclk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ*DW-1:0] wdata_i,
  output logic [NREQ-1:0]    ack_o,
  input  logic               wfull_i,
  output logic               wfifo_o,
  output logic [DW-1:0]      wdata_o,
  output logic [IW-1:0]      gnt_id_o,
  output logic               busy_o
);
  localparam int CW = $clog2(BURST) + 1;
  typedef enum logic {S_IDLE, S_BURST} state_t;
  state_t        r_state, w_state_nxt;
  logic [IW-1:0] r_gnt_id, r_last, w_pick, w_k, w_gnt_nxt, w_last_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          w_busy, w_own_req, w_accept, w_exit;
  assign w_busy    = r_state == S_BURST;
  assign w_own_req = req_i[r_gnt_id];
  assign w_accept  = w_busy & w_own_req & ~wfull_i;
  assign w_exit    = w_busy & ((w_accept & (r_cnt == CW'(BURST - 1))) | ~w_own_req);
  // scan from farthest to nearest so the first requester after r_last overwrites the rest
  always_comb begin
    w_pick = r_last;
    w_k    = r_last;
    for (int i = NREQ; i >= 1; i--) begin
      w_k = IW'((int'(r_last) + i) % NREQ);
      if (req_i[w_k]) w_pick = w_k;
    end
`ifdef SYNC_FIFOWR_ARB_PRIO_EN
    if (req_i[0]) w_pick = '0;
`endif
  end
  // a burst exit with pending requests regrants in the same cycle, so no dead cycle
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt_id;
    w_last_nxt  = r_last;
    w_cnt_nxt   = w_accept ? r_cnt + CW'(1) : r_cnt;
    if ((!w_busy || w_exit) && (|req_i)) begin
      w_state_nxt = S_BURST;
      w_gnt_nxt   = w_pick;
      w_last_nxt  = w_pick;
      w_cnt_nxt   = '0;
    end else if (w_exit) begin
      w_state_nxt = S_IDLE;
    end
  end
  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_gnt_id <= '0;
      r_last   <= IW'(NREQ - 1);
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_gnt_id <= w_gnt_nxt;
      r_last   <= w_last_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end
  assign wfifo_o  = w_accept;
  assign ack_o    = w_accept ? (NREQ'(1) << r_gnt_id) : '0;
  assign wdata_o  = w_busy ? wdata_i[r_gnt_id*DW +: DW] : '0;
  assign busy_o   = w_busy;
  assign gnt_id_o = r_gnt_id;
endmodule

// File: tb/tb_sync_fifowr_arb.sv
// tb_sync_fifowr_arb: directed and random checks of sync_fifowr_arb against a transaction-level model
module tb_sync_fifowr_arb;
  logic         wclk = 0, rst_n = 0, wfull_i = 0;
  logic [3:0]   req_i = '0, ack_o;
  logic [127:0] wdata_i = '0;
  logic         wfifo_o, busy_o;
  logic [31:0]  wdata_o;
  logic [1:0]   gnt_id_o;
  logic [31:0]  data [4];
  int tests = 0, fails = 0, acks = 0;
  int m_owner = -1, m_beats = 0, m_last = 3, m_gnt = 0;
  always #5 wclk = ~wclk;
  sync_fifowr_arb #(.NREQ(4), .IW(2), .DW(32), .BURST(4)) dut (
    .wclk(wclk), .rst_n(rst_n), .req_i(req_i), .wdata_i(wdata_i), .ack_o(ack_o),
    .wfull_i(wfull_i), .wfifo_o(wfifo_o), .wdata_o(wdata_o), .gnt_id_o(gnt_id_o), .busy_o(busy_o)
  );
  function automatic int rr(logic [3:0] r, int from);
    int k;
`ifdef SYNC_FIFOWR_ARB_PRIO_EN
    if (r[0]) return 0;
`endif
    for (int off = 1; off <= 4; off++) begin
      k = (from + off) % 4;
      if (r[k[1:0]]) return k;
    end
    return -1;
  endfunction
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic setd();
    wdata_i = {data[3], data[2], data[1], data[0]};
  endtask
  task automatic grant();
    m_owner = rr(req_i, m_last);
    m_last  = m_owner;
    m_gnt   = m_owner;
    m_beats = 0;
  endtask
  task automatic model_reset();
    m_owner = -1;
    m_beats = 0;
    m_last  = 3;
    m_gnt   = 0;
  endtask
  task automatic cyc();
    logic own, acc;
    logic [3:0] eack;
    int o;
    #1;
    o    = m_owner;
    own  = (o >= 0) ? req_i[o[1:0]] : 1'b0;
    acc  = own && !wfull_i;
    eack = acc ? 4'(1 << o) : 4'd0;
    chk("busy", 64'(busy_o), 64'(o >= 0));
    chk("gnt", 64'(gnt_id_o), 64'(m_gnt));
    chk("wfifo", 64'(wfifo_o), 64'(acc));
    chk("ack", 64'(ack_o), 64'(eack));
    chk("wdata", 64'(wdata_o), (o >= 0) ? 64'(data[o[1:0]]) : 64'd0);
    if (acc) acks++;
    if (o < 0) begin
      if (req_i != 0) grant();
    end else begin
      if (acc) m_beats++;
      if ((acc && m_beats == 4) || !own) begin
        if (req_i != 0) grant();
        else m_owner = -1;
      end
    end
    @(negedge wclk);
    if (acc) data[o[1:0]] = $urandom;
    setd();
  endtask
  initial begin
    for (int k = 0; k < 4; k++) data[k] = $urandom;
    setd();
    @(negedge wclk);
    #1;
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_gnt", 64'(gnt_id_o), 64'd0);
    chk("rst_wfifo", 64'(wfifo_o), 64'd0);
    chk("rst_ack", 64'(ack_o), 64'd0);
    chk("rst_wdata", 64'(wdata_o), 64'd0);
    rst_n = 1;
    @(negedge wclk);
    req_i = 4'b0010;
    acks = 0;
    repeat (7) cyc();
    req_i = 4'b0000;
    repeat (2) cyc();
    chk("single_beats", 64'(acks), 64'd6);
    chk("single_idle", 64'(busy_o), 64'd0);
    req_i = 4'b1111;
    acks = 0;
    repeat (17) cyc();
    chk("all_beats", 64'(acks), 64'd16);
    req_i = 4'b0000;
    repeat (2) cyc();
    req_i = 4'b0011;
    repeat (3) cyc();
    wfull_i = 1;
    repeat (3) cyc();
    wfull_i = 0;
    repeat (4) cyc();
    req_i = 4'b0000;
    repeat (2) cyc();
    req_i = 4'b0010;
    repeat (3) cyc();
    #2;
    rst_n = 0;
    #1;
    chk("arst_wfifo", 64'(wfifo_o), 64'd0);
    chk("arst_ack", 64'(ack_o), 64'd0);
    chk("arst_busy", 64'(busy_o), 64'd0);
    model_reset();
    @(negedge wclk);
    rst_n = 1;
    req_i = 4'b1100;
    cyc();
    chk("arst_first_gnt", 64'(gnt_id_o), 64'd2);
    repeat (2) cyc();
    req_i = 4'b1000;
    cyc();
    chk("drop_regrant", 64'(gnt_id_o), 64'd3);
    repeat (2) cyc();
    req_i = 4'b0000;
    repeat (2) cyc();
    req_i = 4'b0101;
    repeat (20) cyc();
    req_i = 4'b0000;
    repeat (2) cyc();
    for (int n = 0; n < 500; n++) begin
      for (int k = 0; k < 4; k++) begin
        if (!req_i[k[1:0]]) req_i[k[1:0]] = ($urandom_range(3) == 0);
        else if ($urandom_range(9) == 0) req_i[k[1:0]] = 1'b0;
      end
      wfull_i = ($urandom_range(4) == 0);
      cyc();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
